mem_stage: RTL and testbench

//  Memory stage of the pipelined ARM core; consumes Exec's M-stage outputs.

---
 rtl/mem_pkg.sv | 14 +
 rtl/wb_pipereg.sv | 37 +++
 rtl/mem_stage.sv | 124 ++++++++++++
 tb/tb_mem_stage.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory stage.
package mem_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned REG_AW_DEF   = 4;
  localparam int unsigned MAX_WAIT_DEF = 255;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_REQ,
    MS_RESP
  } mem_state_t;

endpackage

// File: rtl/wb_pipereg.sv
// M/W pipeline register: captures the result on load; otherwise inserts a bubble
// while holding the last data/address.
module wb_pipereg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic              regwrite_i,
  input  logic              pcsrc_i,
  output logic [DATA_W-1:0] result_o,
  output logic [REG_AW-1:0] waddr_o,
  output logic              regwrite_o,
  output logic              pcsrc_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      result_o   <= '0;
      waddr_o    <= '0;
      regwrite_o <= 1'b0;
      pcsrc_o    <= 1'b0;
    end else if (load_i) begin
      result_o   <= result_i;
      waddr_o    <= waddr_i;
      regwrite_o <= regwrite_i;
      pcsrc_o    <= pcsrc_i;
    end else begin
      regwrite_o <= 1'b0;
      pcsrc_o    <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: drives LDR/STR onto a req/grant/response data bus, stalls the
// upstream pipe while an access is outstanding and registers the W-stage result.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned REG_AW   = REG_AW_DEF,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ValidM,
  input  logic              PCSrcM,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic              MemWriteM,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [REG_AW-1:0] WriteAddrM,
  output logic              DReq,
  output logic              DWe,
  output logic [DATA_W-1:0] DAddr,
  output logic [DATA_W-1:0] DWData,
  input  logic              DGnt,
  input  logic              DRValid,
  input  logic [DATA_W-1:0] DRData,
  output logic              StallM,
  output logic              DataAbort,
  output logic [DATA_W-1:0] ResultW,
  output logic [REG_AW-1:0] WriteAddrW,
  output logic              RegWriteW,
  output logic              PCSrcW
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             memop, timeout, complete, abort, req, wb_load;

  assign memop   = ValidM & (MemtoRegM | MemWriteM);
  assign timeout = (wait_q == CNT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MS_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    unique case (state_q)
      MS_IDLE: begin
        if (memop) begin
          if (DGnt) state_d = MemWriteM ? MS_IDLE : MS_RESP;
          else      state_d = MS_REQ;
        end
      end
      MS_REQ: begin
        if (DGnt)         state_d = MemWriteM ? MS_IDLE : MS_RESP;
        else if (timeout) state_d = MS_IDLE;
      end
      MS_RESP: begin
        if (DRValid || timeout) state_d = MS_IDLE;
      end
      default: state_d = MS_IDLE;
    endcase
    // Saturates so a load granted on its final wait cycle still times out in RESP.
    if (state_q != MS_IDLE) wait_d = timeout ? wait_q : wait_q + 1'b1;
  end

  always_comb begin
    req      = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      MS_IDLE: begin
        req      = memop;
        complete = ~memop | (DGnt & MemWriteM);
      end
      MS_REQ: begin
        req      = 1'b1;
        complete = DGnt & MemWriteM;
        abort    = ~DGnt & timeout;
      end
      MS_RESP: begin
        complete = DRValid;
        abort    = ~DRValid & timeout;
      end
      default: ;
    endcase
  end

  assign DReq      = req & ~reset;
  assign DWe       = MemWriteM;
  assign DAddr     = ALUResultM;
  assign DWData    = WriteDataM;
  assign StallM    = memop & ~complete & ~abort & ~reset;
  assign DataAbort = abort & ~reset;
  assign wb_load   = complete & ValidM & ~reset;

  wb_pipereg #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_wb (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (wb_load),
    .result_i   ((state_q == MS_RESP) ? DRData : ALUResultM),
    .waddr_i    (WriteAddrM),
    .regwrite_i (RegWriteM & ~MemWriteM),
    .pcsrc_i    (PCSrcM),
    .result_o   (ResultW),
    .waddr_o    (WriteAddrW),
    .regwrite_o (RegWriteW),
    .pcsrc_o    (PCSrcW)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: per-instruction transaction model feeds a queue
// of per-cycle expectations that a negedge monitor compares against the DUT.
module tb_mem_stage;

  localparam int MW = 5;

  logic        clk = 1'b1;
  logic        reset, ValidM, PCSrcM, RegWriteM, MemtoRegM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM, DAddr, DWData, DRData, ResultW;
  logic [3:0]  WriteAddrM, WriteAddrW;
  logic        DReq, DWe, DGnt, DRValid, StallM, DataAbort, RegWriteW, PCSrcW;

  always #5 clk = ~clk;

  mem_stage #(.DATA_W(32), .REG_AW(4), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .ValidM(ValidM), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM),
    .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .WriteAddrM(WriteAddrM), .DReq(DReq), .DWe(DWe),
    .DAddr(DAddr), .DWData(DWData), .DGnt(DGnt), .DRValid(DRValid), .DRData(DRData),
    .StallM(StallM), .DataAbort(DataAbort), .ResultW(ResultW), .WriteAddrW(WriteAddrW),
    .RegWriteW(RegWriteW), .PCSrcW(PCSrcW)
  );

  typedef struct {
    bit          stall, dreq, abort;
    logic        dwe;
    logic [31:0] daddr, dwdata, wres;
    logic [3:0]  waddr;
    bit          wrw, wpc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, failures = 0;
  logic [31:0] m_res = '0;
  logic [3:0]  m_addr = '0;

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
    end
  endtask

  // Expectation for the cycle whose inputs are currently driven.
  task automatic push(bit stall, bit dreq, bit abort, bit complete, bit is_load,
                      logic [31:0] rd);
    exp_t e;
    e.stall = stall; e.dreq = dreq; e.abort = abort;
    e.dwe = MemWriteM; e.daddr = ALUResultM; e.dwdata = WriteDataM;
    e.wrw = 0; e.wpc = 0;
    if (reset) begin
      m_res = '0; m_addr = '0;
    end else if (complete && ValidM) begin
      m_res  = is_load ? rd : ALUResultM;
      m_addr = WriteAddrM;
      e.wrw  = RegWriteM && !MemWriteM;
      e.wpc  = PCSrcM;
    end
    e.wres = m_res; e.waddr = m_addr;
    q.push_back(e);
  endtask

  exp_t w_prev;
  bit   have_prev = 0;
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("StallM", {31'b0, StallM}, {31'b0, e.stall});
      chk("DReq", {31'b0, DReq}, {31'b0, e.dreq});
      chk("DataAbort", {31'b0, DataAbort}, {31'b0, e.abort});
      if (e.dreq) begin
        chk("DWe", {31'b0, DWe}, {31'b0, e.dwe});
        chk("DAddr", DAddr, e.daddr);
        chk("DWData", DWData, e.dwdata);
      end
      if (have_prev) begin
        chk("ResultW", ResultW, w_prev.wres);
        chk("WriteAddrW", {28'b0, WriteAddrW}, {28'b0, w_prev.waddr});
        chk("RegWriteW", {31'b0, RegWriteW}, {31'b0, w_prev.wrw});
        chk("PCSrcW", {31'b0, PCSrcW}, {31'b0, w_prev.wpc});
      end
      w_prev = e;
      have_prev = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One instruction: g = wait cycles until grant (0 = same cycle), r = cycles from
  // grant to read data. Stalls for its whole duration except the final cycle.
  task automatic do_instr(bit v, bit pc, bit rw, bit m2r, bit mw, logic [31:0] alu,
                          logic [31:0] wd, logic [3:0] wa, int g, int r, logic [31:0] rd);
    bit memop, ld, ab, last;
    int dur;
    memop = v && (m2r || mw);
    ld    = memop && !mw;
    if (ld && g >= MW) g = MW + 1;
    if (!memop)   begin ab = 0;          dur = 1; end
    else if (!ld) begin ab = (g > MW);     dur = ab ? MW + 1 : g + 1; end
    else          begin ab = (g + r > MW); dur = ab ? MW + 1 : g + r + 1; end
    ValidM = v; PCSrcM = pc; RegWriteM = rw; MemtoRegM = m2r; MemWriteM = mw;
    ALUResultM = alu; WriteDataM = wd; WriteAddrM = wa;
    for (int c = 0; c < dur; c++) begin
      last    = (c == dur - 1);
      DGnt    = (memop && c <= g) ? (c == g) : 1'($urandom_range(0, 1));
      DRValid = (ld && c > g) ? (c == g + r) : 1'($urandom_range(0, 1));
      DRData  = (ld && c == g + r) ? rd : $urandom;
      push(memop && !last, memop && (!ld || c <= g), last && ab, last && !ab, ld, rd);
      step();
    end
    DGnt = 0; DRValid = 0;
  endtask

  initial begin
    reset = 1; ValidM = 0; PCSrcM = 0; RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0;
    ALUResultM = 0; WriteDataM = 0; WriteAddrM = 0; DGnt = 0; DRValid = 0; DRData = 0;
    for (int i = 0; i < 2; i++) begin
      push(0, 0, 0, 0, 0, 0);
      step();
    end
    reset = 0;

    do_instr(1, 0, 1, 0, 0, 32'h1234, 0, 4'd3, 0, 1, 0);
    do_instr(1, 0, 1, 0, 1, 32'h100, 32'hCAFE, 4'd7, 0, 1, 0);
    do_instr(1, 0, 1, 1, 0, 32'h40, 0, 4'd9, 2, 3, 32'hDEADBEEF);
    do_instr(1, 0, 1, 1, 0, 32'h44, 0, 4'd10, MW + 1, 1, 0);
    do_instr(1, 0, 0, 0, 1, 32'h48, 32'h55, 4'd2, 0, 1, 0);
    do_instr(0, 1, 1, 0, 1, 32'h4C, 32'h66, 4'd1, 0, 1, 0);
    do_instr(1, 1, 1, 0, 0, 32'h50, 0, 4'd15, 0, 1, 0);
    do_instr(1, 0, 0, 0, 1, 32'h54, 32'h1, 4'd0, 0, 1, 0);
    do_instr(1, 0, 0, 0, 1, 32'h58, 32'h2, 4'd0, MW, 1, 0);
    do_instr(1, 0, 1, 1, 0, 32'h5C, 0, 4'd6, 1, MW - 1, 32'h0BADF00D);

    // Reset while a load waits in RESP; read data arriving afterwards is ignored.
    ValidM = 1; PCSrcM = 0; RegWriteM = 1; MemtoRegM = 1; MemWriteM = 0;
    ALUResultM = 32'h200; WriteAddrM = 4'd5; DGnt = 1;
    push(1, 1, 0, 0, 1, 0); step();
    DGnt = 0;
    push(1, 0, 0, 0, 1, 0); step();
    reset = 1; DRValid = 1; DRData = 32'h12345678;
    push(0, 0, 0, 0, 1, 0); step();
    push(0, 0, 0, 0, 1, 0); step();
    reset = 0; ValidM = 0;
    push(0, 0, 0, 1, 0, 0); step();
    DRValid = 0;

    for (int i = 0; i < 400; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      do_instr(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), kind == 1, kind == 2, $urandom, $urandom,
               4'($urandom), $urandom_range(0, MW + 1), $urandom_range(1, 4), $urandom);
    end

    ValidM = 0;
    push(0, 0, 0, 1, 0, 0); step();
    repeat (3) step();
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
